// File: rtl/bcd_scan_display.sv
// Multiplexed common-anode 7-segment driver for a chain of BCD counter digits.
// Shadow-captures the digits, scans them at a prescaled rate, blanks leading zeros
// and inserts a one-cycle all-anodes-off gap on every digit switch.
module bcd_scan_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    capture,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        scan_idx
);

  localparam int              PRE_W    = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic             MULTI    = (NUM_DIGITS > 1) ? 1'b1 : 1'b0;

  // Active-high gfedcba pattern; codes 10..15 show a dash.
  function automatic logic [6:0] decode_seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = 7'h3F;
      4'd1:    pat = 7'h06;
      4'd2:    pat = 7'h5B;
      4'd3:    pat = 7'h4F;
      4'd4:    pat = 7'h66;
      4'd5:    pat = 7'h6D;
      4'd6:    pat = 7'h7D;
      4'd7:    pat = 7'h07;
      4'd8:    pat = 7'h7F;
      4'd9:    pat = 7'h6F;
      default: pat = 7'h40;
    endcase
    return pat;
  endfunction

  logic [4*NUM_DIGITS-1:0] shadow_r, shadow_nxt_s;
  logic [NUM_DIGITS-1:0]   shadow_dp_r, shadow_dp_nxt_s;
  logic [PRE_W-1:0]        pre_r, pre_nxt_s;
  logic [IDX_W-1:0]        scan_idx_r, idx_nxt_s;
  logic                    gap_r, gap_nxt_s, tick_s;
  logic [6:0]              seg_r, seg_nxt_s;
  logic                    dp_r, dp_nxt_s;
  logic [NUM_DIGITS-1:0]   an_r, an_nxt_s;
  logic [3:0]              cur_digit_s;
  logic                    cur_dp_s, cur_blank_s, zero_above_s;

  // Next-state for shadow, prescaler and scan position.
  always_comb begin
    shadow_nxt_s    = shadow_r;
    shadow_dp_nxt_s = shadow_dp_r;
    if (capture) begin
      shadow_nxt_s    = digits_in;
      shadow_dp_nxt_s = dp_in;
    end else begin
      shadow_nxt_s    = shadow_r;
      shadow_dp_nxt_s = shadow_dp_r;
    end

    tick_s    = (pre_r == PRE_LAST);
    pre_nxt_s = tick_s ? {PRE_W{1'b0}} : pre_r + PRE_W'(1);

    if (tick_s) begin
      if (scan_idx_r == IDX_LAST) begin
        idx_nxt_s = {IDX_W{1'b0}};
      end else begin
        idx_nxt_s = scan_idx_r + IDX_W'(1);
      end
      gap_nxt_s = MULTI;
    end else begin
      idx_nxt_s = scan_idx_r;
      gap_nxt_s = 1'b0;
    end
  end

  // Output pattern from the post-update scan position and shadow contents.
  always_comb begin
    cur_digit_s  = 4'h0;
    cur_dp_s     = 1'b0;
    cur_blank_s  = 1'b0;
    zero_above_s = 1'b1;
    an_nxt_s     = {NUM_DIGITS{1'b1}};
    // Walk from the most significant digit so zero_above_s covers digit i and all above it.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above_s = zero_above_s & (shadow_nxt_s[4*i +: 4] == 4'h0);
      if (idx_nxt_s == IDX_W'(i)) begin
        cur_digit_s = shadow_nxt_s[4*i +: 4];
        cur_dp_s    = shadow_dp_nxt_s[i];
        cur_blank_s = blank_lz & zero_above_s & (i > 0);
        an_nxt_s[i] = gap_nxt_s;
      end else begin
        an_nxt_s[i] = 1'b1;
      end
    end
    if (cur_blank_s) begin
      seg_nxt_s = 7'h7F;
    end else begin
      seg_nxt_s = ~decode_seg(cur_digit_s);
    end
    dp_nxt_s = ~cur_dp_s;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_r    <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r <= {NUM_DIGITS{1'b0}};
      pre_r       <= {PRE_W{1'b0}};
      scan_idx_r  <= {IDX_W{1'b0}};
      gap_r       <= 1'b0;
      seg_r       <= 7'h7F;
      dp_r        <= 1'b1;
      an_r        <= {NUM_DIGITS{1'b1}};
    end else begin
      shadow_r    <= shadow_nxt_s;
      shadow_dp_r <= shadow_dp_nxt_s;
      pre_r       <= pre_nxt_s;
      scan_idx_r  <= idx_nxt_s;
      gap_r       <= gap_nxt_s;
      seg_r       <= seg_nxt_s;
      dp_r        <= dp_nxt_s;
      an_r        <= an_nxt_s;
    end
  end

  assign seg      = seg_r;
  assign dp       = dp_r;
  assign an       = an_r;
  assign scan_idx = scan_idx_r;

  logic unused_gap_s;
  assign unused_gap_s = gap_r;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: cycle-by-cycle model comparison plus hand-computed pin values.
module tb_bcd_scan_display;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam logic [6:0] PIN [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic        clk = 1'b0;
  logic        reset, capture, blank_lz;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  scan_idx;

  int n_cmp = 0;
  int n_bad = 0;

  bcd_scan_display #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .dp_in(dp_in),
    .capture(capture), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .an(an), .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] digit_pin(input int d);
    if (d > 9) return 7'h3F;
    return PIN[d];
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: edges since reset release, plus captured shadow copy.
  int          k = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;
  always begin
    int e_idx, d;
    bit blank;
    logic [6:0] e_seg;
    logic e_dp;
    logic [3:0] e_an;
    @(posedge clk);
    #1;
    if (reset) begin
      k = 0; m_sh = 16'h0; m_dp = 4'h0; m_valid = 1'b1;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_idx = 0;
    end else begin
      k++;
      if (capture) begin
        m_sh = digits_in; m_dp = dp_in;
      end
      e_idx = (k / RD) % ND;
      d     = int'((m_sh >> (4*e_idx)) & 16'hF);
      blank = blank_lz && (e_idx > 0) && ((m_sh >> (4*e_idx)) == 16'h0);
      e_seg = blank ? 7'h7F : digit_pin(d);
      e_dp  = !m_dp[e_idx];
      e_an  = (k % RD == 0) ? 4'hF : ~(4'b0001 << e_idx);
    end
    if (m_valid)
      chk("model", {2'b00, seg, dp, an, scan_idx}, {2'b00, e_seg, e_dp, e_an, 2'(e_idx)});
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [6:0] s1 [16];
  initial begin
    int cnt;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit found;
    reset = 1'b1; capture = 1'b0; blank_lz = 1'b0; digits_in = 16'h0; dp_in = 4'h0;
    repeat (3) cyc();
    chk("reset_seg", {9'h0, seg}, 16'h7F);
    chk("reset_dp_an_idx", {9'h0, dp, an, scan_idx}, {9'h0, 1'b1, 4'hF, 2'd0});
    reset = 1'b0;
    cyc();                                             // k=1
    chk("first_an", {12'h0, an}, 16'hE);
    capture = 1'b1; digits_in = 16'h1234;
    cyc();                                             // k=2
    capture = 1'b0;
    chk("slot0_seg4", {9'h0, seg}, 16'h19);
    chk("slot0_an", {12'h0, an}, 16'hE);
    repeat (2) cyc();                                  // k=4
    chk("gap_an", {12'h0, an}, 16'hF);
    chk("slot1_seg3", {9'h0, seg}, 16'h30);
    chk("slot1_idx", {14'h0, scan_idx}, 16'd1);
    cyc();                                             // k=5
    chk("slot1_an", {12'h0, an}, 16'hD);
    repeat (11) cyc();                                 // k=16
    chk("wrap_idx", {14'h0, scan_idx}, 16'd0);

    capture = 1'b1; digits_in = 16'h0050; blank_lz = 1'b1;
    cyc();                                             // k=17
    capture = 1'b0;
    chk("lz_d0", {9'h0, seg}, 16'h40);
    repeat (3) cyc();                                  // k=20
    chk("lz_d1", {9'h0, seg}, 16'h12);
    repeat (4) cyc();                                  // k=24
    chk("lz_d2_blank", {9'h0, seg}, 16'h7F);
    repeat (4) cyc();                                  // k=28
    chk("lz_d3_blank", {9'h0, seg}, 16'h7F);
    blank_lz = 1'b0;
    cyc();                                             // k=29
    chk("nolz_d3", {9'h0, seg}, 16'h40);

    blank_lz = 1'b1; capture = 1'b1; digits_in = 16'h0A00;
    cyc();                                             // k=30
    capture = 1'b0;
    repeat (6) cyc();                                  // k=36
    chk("inv_below_d1", {9'h0, seg}, 16'h40);
    repeat (4) cyc();                                  // k=40
    chk("inv_dash", {9'h0, seg}, 16'h3F);
    chk("inv_idx", {14'h0, scan_idx}, 16'd2);
    repeat (4) cyc();                                  // k=44
    chk("inv_d3_blank", {9'h0, seg}, 16'h7F);

    capture = 1'b1; digits_in = 16'h9876; dp_in = 4'b0100;
    cyc();                                             // k=45
    capture = 1'b0;
    repeat (3) cyc();                                  // k=48
    for (int i = 0; i < 16; i++) begin
      cyc();
      s1[i] = seg;
      chk("dp_slot", {15'h0, dp}, (scan_idx == 2'd2) ? 16'd0 : 16'd1);
    end
    for (int i = 0; i < 16; i++) begin
      digits_in = 16'($urandom);
      cyc();
      chk("no_tear", {9'h0, seg}, {9'h0, s1[i]});
    end

    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (scan_idx == 2'd2) found = 1'b1;
    end
    chk("reach_idx2", {15'h0, found}, 16'd1);
    reset = 1'b1;
    cyc();
    chk("midreset_seg", {9'h0, seg}, 16'h7F);
    chk("midreset_rest", {9'h0, dp, an, scan_idx}, {9'h0, 1'b1, 4'hF, 2'd0});
    reset = 1'b0;
    cnt = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (scan_idx == 2'd0) cnt++;
      else found = 1'b1;
    end
    chk("idx0_hold", 16'(cnt), 16'(RD));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
